// File: rtl/axi_lite_pkg.sv
// Shared AXI-Lite definitions: response codes, default widths and the
// command-master state encoding.
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef ADDR_W
`define ADDR_W 32
`endif

package axi_lite_pkg;

   localparam int AXIL_DATA_W = `DATA_W;
   localparam int AXIL_ADDR_W = `ADDR_W;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_RSP     = 3'd5
   } axil_mst_state_t;

endpackage

// File: rtl/axi_lite_cmd_master.sv
// AXI-Lite initiator: one command in, one single-beat AXI-Lite transaction
// out, one completion (with latency count) back. One transaction in flight.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | cmd_ready high, waiting for a command
// ST_WR_REQ  | AW and W presented; each drops on its own handshake
// ST_WR_RESP | bready high, waiting for the B beat
// ST_RD_REQ  | AR presented, waiting for arready
// ST_RD_RESP | rready high, waiting for the R beat
// ST_RSP     | completion held on the rsp stream until rsp_ready
module axi_lite_cmd_master
   import axi_lite_pkg::*;
#(
   parameter int DATA_WIDTH = AXIL_DATA_W,
   parameter int ADDR_WIDTH = AXIL_ADDR_W,
   parameter int LAT_WIDTH  = 16
) (
   input  logic                    m_axi_aclk,
   input  logic                    m_axi_areset,

   input  logic                    cmd_valid,
   output logic                    cmd_ready,
   input  logic                    cmd_write,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic                    rsp_write,
   output logic [DATA_WIDTH-1:0]   rsp_rdata,
   output logic [1:0]              rsp_resp,
   output logic [LAT_WIDTH-1:0]    rsp_lat,

   output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic                    m_axi_awvalid,
   input  logic                    m_axi_awready,
   output logic [DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                    m_axi_wvalid,
   input  logic                    m_axi_wready,
   input  logic [1:0]              m_axi_bresp,
   input  logic                    m_axi_bvalid,
   output logic                    m_axi_bready,
   output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
   output logic                    m_axi_arvalid,
   input  logic                    m_axi_arready,
   input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
   input  logic [1:0]              m_axi_rresp,
   input  logic                    m_axi_rvalid,
   output logic                    m_axi_rready
);

   axil_mst_state_t state, state_n;

   logic awvalid_n, wvalid_n, arvalid_n, bready_n, rready_n, rsp_valid_n;
   logic accept, b_hs, r_hs;
   logic [LAT_WIDTH-1:0] lat_cnt, lat_inc;

   // The only combinational output; held low during reset so nothing is
   // accepted on the reset edge.
   assign cmd_ready = (state == ST_IDLE) && !m_axi_areset;

   // Latency as seen at a handshake edge: counter value after this edge.
   assign lat_inc = (&lat_cnt) ? lat_cnt : lat_cnt + 1'b1;

   // State register.
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) state <= ST_IDLE;
      else              state <= state_n;
   end

   // Next state and next values of the registered valid/ready outputs.
   always_comb begin
      state_n     = state;
      awvalid_n   = m_axi_awvalid;
      wvalid_n    = m_axi_wvalid;
      arvalid_n   = m_axi_arvalid;
      bready_n    = m_axi_bready;
      rready_n    = m_axi_rready;
      rsp_valid_n = rsp_valid;
      accept      = 1'b0;
      b_hs        = 1'b0;
      r_hs        = 1'b0;
      case (state)
         ST_IDLE: begin
            if (cmd_valid && cmd_ready) begin
               accept = 1'b1;
               if (cmd_write) begin
                  state_n   = ST_WR_REQ;
                  awvalid_n = 1'b1;
                  wvalid_n  = 1'b1;
               end else begin
                  state_n   = ST_RD_REQ;
                  arvalid_n = 1'b1;
               end
            end
         end
         ST_WR_REQ: begin
            awvalid_n = m_axi_awvalid && !m_axi_awready;
            wvalid_n  = m_axi_wvalid && !m_axi_wready;
            if (!awvalid_n && !wvalid_n) begin
               state_n  = ST_WR_RESP;
               bready_n = 1'b1;
            end
         end
         ST_WR_RESP: begin
            if (m_axi_bvalid && m_axi_bready) begin
               b_hs        = 1'b1;
               bready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = ST_RSP;
            end
         end
         ST_RD_REQ: begin
            if (m_axi_arvalid && m_axi_arready) begin
               arvalid_n = 1'b0;
               rready_n  = 1'b1;
               state_n   = ST_RD_RESP;
            end
         end
         ST_RD_RESP: begin
            if (m_axi_rvalid && m_axi_rready) begin
               r_hs        = 1'b1;
               rready_n    = 1'b0;
               rsp_valid_n = 1'b1;
               state_n     = ST_RSP;
            end
         end
         ST_RSP: begin
            if (rsp_ready) begin
               rsp_valid_n = 1'b0;
               state_n     = ST_IDLE;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Registered handshake outputs.
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         m_axi_awvalid <= 1'b0;
         m_axi_wvalid  <= 1'b0;
         m_axi_arvalid <= 1'b0;
         m_axi_bready  <= 1'b0;
         m_axi_rready  <= 1'b0;
         rsp_valid     <= 1'b0;
      end else begin
         m_axi_awvalid <= awvalid_n;
         m_axi_wvalid  <= wvalid_n;
         m_axi_arvalid <= arvalid_n;
         m_axi_bready  <= bready_n;
         m_axi_rready  <= rready_n;
         rsp_valid     <= rsp_valid_n;
      end
   end

   // Command capture, latency counter and completion capture.
   always_ff @(posedge m_axi_aclk) begin
      if (m_axi_areset) begin
         m_axi_awaddr <= '0;
         m_axi_wdata  <= '0;
         m_axi_wstrb  <= '0;
         m_axi_araddr <= '0;
         rsp_write    <= 1'b0;
         rsp_rdata    <= '0;
         rsp_resp     <= '0;
         rsp_lat      <= '0;
         lat_cnt      <= '0;
      end else begin
         if (accept) begin
            lat_cnt <= '0;
            if (cmd_write) begin
               m_axi_awaddr <= cmd_addr;
               m_axi_wdata  <= cmd_wdata;
               m_axi_wstrb  <= cmd_wstrb;
            end else begin
               m_axi_araddr <= cmd_addr;
            end
         end else if (state != ST_IDLE) begin
            lat_cnt <= lat_inc;
         end
         if (b_hs) begin
            rsp_write <= 1'b1;
            rsp_rdata <= '0;
            rsp_resp  <= m_axi_bresp;
            rsp_lat   <= lat_inc;
         end
         if (r_hs) begin
            rsp_write <= 1'b0;
            rsp_rdata <= m_axi_rdata;
            rsp_resp  <= m_axi_rresp;
            rsp_lat   <= lat_inc;
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Directed bench for axi_lite_cmd_master; the AXI-Lite slave is driven
// cycle by cycle from each scenario task.
module tb_axi_lite_cmd_master;
   import axi_lite_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        areset;
   logic        cmd_valid, cmd_ready, cmd_write;
   logic [31:0] cmd_addr, cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic        rsp_valid, rsp_ready, rsp_write;
   logic [31:0] rsp_rdata;
   logic [1:0]  rsp_resp;
   logic [15:0] rsp_lat;
   logic [31:0] awaddr, wdata, araddr, rdata;
   logic [3:0]  wstrb;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic        arvalid, arready, rvalid, rready;
   logic [1:0]  bresp, rresp;

   int errors = 0;
   int checks = 0;

   axi_lite_cmd_master dut (
      .m_axi_aclk(clk), .m_axi_areset(areset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
      .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
      .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_lat(rsp_lat),
      .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
      .m_axi_wdata(wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid),
      .m_axi_wready(wready), .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
      .m_axi_bready(bready), .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
      .m_axi_arready(arready), .m_axi_rdata(rdata), .m_axi_rresp(rresp),
      .m_axi_rvalid(rvalid), .m_axi_rready(rready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      areset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
      rsp_ready = 1'b0;
      awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0;
      arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0;
      repeat (3) tick();
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_cmd_ready got %0h exp 0", cmd_ready); end
      checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0) begin errors++; $display("FAIL rst_valids got %b exp 000000", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}); end
      checks++; if ({awaddr, wdata, wstrb, araddr} !== 100'b0) begin errors++; $display("FAIL rst_axi_fields got nonzero exp 0"); end
      checks++; if ({rsp_rdata, rsp_resp, rsp_lat, rsp_write} !== 51'b0) begin errors++; $display("FAIL rst_rsp_fields got nonzero exp 0"); end
      areset = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_release_cmd_ready got %0h exp 1", cmd_ready); end
   endtask

   task automatic test_write_zero_wait();
      awready = 1'b1; wready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_wdata = 32'hDEADBEEF; cmd_wstrb = 4'hF;
      tick();
      cmd_valid = 1'b0;
      checks++; if ({awvalid, wvalid, bready} !== 3'b110) begin errors++; $display("FAIL wr0_req_valids got %b exp 110", {awvalid, wvalid, bready}); end
      checks++; if (awaddr !== 32'h10) begin errors++; $display("FAIL wr0_awaddr got %0h exp 10", awaddr); end
      checks++; if (wdata !== 32'hDEADBEEF || wstrb !== 4'hF) begin errors++; $display("FAIL wr0_wdata got %0h/%0h exp deadbeef/f", wdata, wstrb); end
      tick();
      checks++; if ({awvalid, wvalid, bready, rsp_valid} !== 4'b0010) begin errors++; $display("FAIL wr0_bready_stage got %b exp 0010", {awvalid, wvalid, bready, rsp_valid}); end
      bvalid = 1'b1; bresp = RESP_OKAY;
      tick();
      bvalid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL wr0_rsp_valid got %0h/%0h exp 1/0", rsp_valid, bready); end
      checks++; if (rsp_lat !== 16'd2) begin errors++; $display("FAIL wr0_lat got %0d exp 2", rsp_lat); end
      checks++; if (rsp_resp !== 2'b00 || rsp_rdata !== 32'h0 || rsp_write !== 1'b1) begin errors++; $display("FAIL wr0_rsp_fields got %0h/%0h/%0h exp 0/0/1", rsp_resp, rsp_rdata, rsp_write); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wr0_done got %0h/%0h exp 0/1", rsp_valid, cmd_ready); end
      awready = 1'b0; wready = 1'b0;
   endtask

   task automatic test_read_delayed();
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h14;
      tick();
      cmd_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++; if (arvalid !== 1'b1 || araddr !== 32'h14) begin errors++; $display("FAIL rd_arvalid_hold[%0d] got %0h/%0h exp 1/14", i, arvalid, araddr); end
         if (i == 3) arready = 1'b1;
         tick();
      end
      arready = 1'b0;
      checks++; if (arvalid !== 1'b0 || rready !== 1'b1) begin errors++; $display("FAIL rd_after_ar got %0h/%0h exp 0/1", arvalid, rready); end
      tick();
      tick();
      checks++; if (rready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_r got %0h/%0h exp 1/0", rready, rsp_valid); end
      rvalid = 1'b1; rdata = 32'h12345678; rresp = RESP_OKAY;
      tick();
      rvalid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h12345678) begin errors++; $display("FAIL rd_rdata got %0h/%0h exp 1/12345678", rsp_valid, rsp_rdata); end
      checks++; if (rsp_lat !== 16'd7) begin errors++; $display("FAIL rd_lat got %0d exp 7", rsp_lat); end
      checks++; if (rsp_write !== 1'b0 || rready !== 1'b0) begin errors++; $display("FAIL rd_write_flag got %0h/%0h exp 0/0", rsp_write, rready); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_write_early_b();
      awready = 1'b1; wready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h5A5A5A5A; cmd_wstrb = 4'h3;
      tick();
      cmd_valid = 1'b0;
      tick();
      awready = 1'b0;
      checks++; if ({awvalid, wvalid, bready} !== 3'b010) begin errors++; $display("FAIL wrb_indep_drop got %b exp 010", {awvalid, wvalid, bready}); end
      tick();
      bvalid = 1'b1; bresp = RESP_OKAY;
      checks++; if (bready !== 1'b0) begin errors++; $display("FAIL wrb_no_bready_in_req got %0h exp 0", bready); end
      tick();
      bvalid = 1'b0;
      checks++; if (bready !== 1'b0 || wvalid !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wrb_early_b_ignored got %0h/%0h/%0h exp 0/1/0", bready, wvalid, rsp_valid); end
      tick();
      wready = 1'b1;
      tick();
      wready = 1'b0;
      checks++; if (wvalid !== 1'b0 || bready !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL wrb_after_w got %0h/%0h/%0h exp 0/1/0", wvalid, bready, rsp_valid); end
      tick();
      bvalid = 1'b1;
      tick();
      bvalid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_lat !== 16'd7 || rsp_resp !== RESP_OKAY) begin errors++; $display("FAIL wrb_rsp got %0h/%0d/%0h exp 1/7/0", rsp_valid, rsp_lat, rsp_resp); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL wrb_single_rsp[%0d] got %0h/%0h exp 0/1", i, rsp_valid, cmd_ready); end
         tick();
      end
   endtask

   task automatic test_read_slverr_backpressure();
      arready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h30;
      tick();
      cmd_valid = 1'b0;
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rresp = RESP_SLVERR; rdata = 32'h0000CAFE;
      tick();
      rvalid = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h40; cmd_wdata = 32'h11223344; cmd_wstrb = 4'hF;
      for (int i = 0; i < 5; i++) begin
         checks++; if (rsp_valid !== 1'b1 || rsp_resp !== RESP_SLVERR || rsp_rdata !== 32'h0000CAFE || rsp_lat !== 16'd2 || rsp_write !== 1'b0) begin errors++; $display("FAIL bp_rsp_stable[%0d] got %0h/%0h/%0h/%0d exp 1/2/cafe/2", i, rsp_valid, rsp_resp, rsp_rdata, rsp_lat); end
         checks++; if (cmd_ready !== 1'b0 || awvalid !== 1'b0) begin errors++; $display("FAIL bp_no_accept[%0d] got %0h/%0h exp 0/0", i, cmd_ready, awvalid); end
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      checks++; if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL bp_release got %0h/%0h exp 0/1", rsp_valid, cmd_ready); end
      awready = 1'b1; wready = 1'b1;
      tick();
      cmd_valid = 1'b0;
      checks++; if (awvalid !== 1'b1 || awaddr !== 32'h40) begin errors++; $display("FAIL bp_next_accept got %0h/%0h exp 1/40", awvalid, awaddr); end
      tick();
      awready = 1'b0; wready = 1'b0;
      bvalid = 1'b1; bresp = RESP_DECERR;
      tick();
      bvalid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_resp !== RESP_DECERR || rsp_lat !== 16'd2) begin errors++; $display("FAIL bp_next_rsp got %0h/%0h/%0d exp 1/3/2", rsp_valid, rsp_resp, rsp_lat); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_saturate();
      awready = 1'b0; wready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h50; cmd_wdata = 32'h1; cmd_wstrb = 4'h1;
      tick();
      cmd_valid = 1'b0;
      tick();
      wready = 1'b0;
      checks++; if (wvalid !== 1'b0 || awvalid !== 1'b1) begin errors++; $display("FAIL sat_w_first got %0h/%0h exp 0/1", wvalid, awvalid); end
      repeat (70000) tick();
      checks++; if (awvalid !== 1'b1 || bready !== 1'b0) begin errors++; $display("FAIL sat_aw_held got %0h/%0h exp 1/0", awvalid, bready); end
      awready = 1'b1;
      tick();
      awready = 1'b0;
      bvalid = 1'b1; bresp = RESP_OKAY;
      tick();
      bvalid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_lat !== 16'hFFFF) begin errors++; $display("FAIL sat_lat got %0h/%0h exp 1/ffff", rsp_valid, rsp_lat); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   task automatic test_reset_mid();
      awready = 1'b0; wready = 1'b0;
      cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h60; cmd_wdata = 32'h2; cmd_wstrb = 4'hF;
      tick();
      cmd_valid = 1'b0;
      checks++; if (awvalid !== 1'b1 || wvalid !== 1'b1) begin errors++; $display("FAIL rstmid_in_req got %0h/%0h exp 1/1", awvalid, wvalid); end
      areset = 1'b1;
      tick();
      checks++; if ({awvalid, wvalid, arvalid, bready, rready, rsp_valid} !== 6'b0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL rstmid_drop got %b/%0h exp 000000/0", {awvalid, wvalid, arvalid, bready, rready, rsp_valid}, cmd_ready); end
      areset = 1'b0;
      #1;
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rstmid_release got %0h exp 1", cmd_ready); end
      arready = 1'b1;
      cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h64;
      tick();
      cmd_valid = 1'b0;
      checks++; if (arvalid !== 1'b1 || araddr !== 32'h64 || awvalid !== 1'b0) begin errors++; $display("FAIL rstmid_read_req got %0h/%0h/%0h exp 1/64/0", arvalid, araddr, awvalid); end
      tick();
      arready = 1'b0;
      rvalid = 1'b1; rdata = 32'h0BADF00D; rresp = RESP_OKAY;
      tick();
      rvalid = 1'b0;
      checks++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0BADF00D || rsp_lat !== 16'd2 || rsp_resp !== RESP_OKAY) begin errors++; $display("FAIL rstmid_read_rsp got %0h/%0h/%0d/%0h exp 1/badf00d/2/0", rsp_valid, rsp_rdata, rsp_lat, rsp_resp); end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_write_zero_wait();
      test_read_delayed();
      test_write_early_b();
      test_read_slverr_backpressure();
      test_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/axi_lite_cmd_master.md
# axi_lite_cmd_master

AXI-Lite initiator that turns a simple command stream into single AXI-Lite write or read transactions and returns each completion on a response stream. It is the master-side counterpart of the shell's AXI-Lite slave ports. It drives the FIFO accelerator's register interface from on-chip logic, for self-test or a local sequencer, without the PCIe host. It allows one transaction in flight and reports a per-transaction latency count for performance measurement.

## Interface
- DATA_WIDTH, 32, AXI-Lite data width; `cmd_wstrb` is DATA_WIDTH/8 bits.
- ADDR_WIDTH, 32, AXI-Lite address width.
- LAT_WIDTH, 16, width of the saturating latency counter.
- m_axi_aclk  in  1  sole clock.
- m_axi_areset  in  1  reset, synchronous, active-high.
- cmd_valid / cmd_ready  in / out  1 each  command handshake.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  target address.
- cmd_wdata  in  DATA_WIDTH  write data (ignored for reads).
- cmd_wstrb  in  DATA_WIDTH/8  write strobes (ignored for reads).
- rsp_valid / rsp_ready  out / in  1 each  response handshake.
- rsp_write  out  1  echo of cmd_write.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  BRESP or RRESP as received.
- rsp_lat  out  LAT_WIDTH  cycles from command accept to B/R handshake.
- m_axi_awaddr/awvalid/awready, m_axi_wdata/wstrb/wvalid/wready, m_axi_bresp/bvalid/bready, m_axi_araddr/arvalid/arready, m_axi_rdata/rresp/rvalid/rready  standard AXI-Lite master channels (ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8 / 2 bits).

## Operation
- States:
  - IDLE → WR_REQ when `cmd_write` is 1 on command accept; IDLE → RD_REQ when it is 0.
  - WR_REQ → WR_RESP.
  - RD_REQ → RD_RESP.
  - WR_RESP / RD_RESP → RSP.
  - RSP → IDLE.
- IDLE: `cmd_ready` = 1. On accept, register addr, wdata, wstrb and write; clear the latency counter to 0.
- WR_REQ: `awvalid` and `wvalid` both rise the cycle after accept.
  - Each drops independently on its own handshake (awvalid&awready, wvalid&wready).
  - Leave for WR_RESP once both handshakes are done; same-cycle completion of both is legal.
- WR_RESP: `bready` = 1. On bvalid&bready, capture bresp, rdata = 0, lat = counter; go to RSP.
  - A B beat arriving while still in WR_REQ is not accepted; `bready` stays 0 there.
- RD_REQ: `arvalid` = 1 until arready; then go to RD_RESP.
- RD_RESP: `rready` = 1. On rvalid&rready, capture rdata, rresp, lat = counter; go to RSP.
- RSP: `rsp_valid` = 1. Outputs hold stable until `rsp_ready`; then return to IDLE.
- Latency counter: +1 every cycle after accept, saturates at all-ones and does not wrap.
- AXI valid signals never depend on ready, and stay asserted until their handshake.
- `rsp_resp` is passed through unmodified. SLVERR and DECERR are reported, not retried.
- Reset mid-operation: next edge forces IDLE and drops all valids and readys. The in-flight transaction is abandoned; the slave is reset with the same reset.

## Timing
- All outputs are registered except `cmd_ready`, which is decoded from state == IDLE and forced to 0 while `m_axi_areset` is high.
- Reset values: every valid/ready output 0; awaddr, wdata, wstrb, araddr, rsp_rdata, rsp_resp, rsp_lat, rsp_write all 0.
- Write with zero-wait slave:
  - accept at cycle 0;
  - aw/w handshake at cycle 1;
  - B handshake at cycle 2;
  - `rsp_valid` at cycle 3 with rsp_lat = 2.
- Read with zero-wait slave: accept at 0, AR at 1, R at 2, `rsp_valid` at 3, rsp_lat = 2.
- Throughput: best case one transaction per 4 cycles. The next command can be accepted the cycle after the rsp handshake.
- Back-pressure on the rsp stream stalls the block indefinitely; no command is accepted meanwhile.

## Structure
- Shared package `axi_lite_pkg`:
  - response constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11;
  - state enum `axil_mst_state_t`.
- Parameter defaults track the `DATA_W` / `ADDR_W` defines.
- Single module; no sub-module is warranted.

## Test plan
- Write addr 0x10, data 0xDEADBEEF, strb 0xF; zero-wait slave → AW/W at cycle 1, bready at 2, rsp_valid at 3, rsp_resp 00, rsp_lat 2, rsp_rdata 0.
- Read 0x14; slave delays arready 3 cycles and rvalid 2 more cycles, returning 0x12345678 → rsp_rdata 0x12345678, rsp_lat 7, arvalid held steady throughout.
- Write with wready 4 cycles after awready; slave pulses bvalid before wready → B not accepted until after the W handshake; exactly one response.
- Read with rresp SLVERR, then rsp_ready held 0 for 5 cycles → rsp outputs stable, cmd_ready 0 until release; next command accepted the cycle after.
- Slave stalls awready 70000 cycles → rsp_lat = 0xFFFF (saturated).
- Assert reset while in WR_REQ → next cycle all valids 0, cmd_ready 0; after release cmd_ready 1 and a fresh read completes normally.
